// File: rtl/uart_rx_oversampled.sv
// UART receiver clocked by a 16x oversampling Tick: Rx synchroniser, start-bit detect,
// centre sampling, stop check. Define UART_RX_PARITY_EN to add an even-parity bit.
module uart_rx_oversampled #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Tick,
    input  logic            Rx,
    output logic [DBIT-1:0] RxData,
    output logic            RxDone,
    output logic            FrameErr,
    output logic            ParityErr,
    output logic            Busy
);

    localparam int SW = (SB_TICK > 16) ? 5 : 4;
    localparam int NW = (DBIT > 8) ? 4 : 3;

    localparam logic [SW-1:0] C_MID  = SW'(7);
    localparam logic [SW-1:0] C_BIT  = SW'(15);
    localparam logic [SW-1:0] C_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] C_LAST = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t          r_state;
    logic            r_rx_meta;
    logic            r_rx_s;
    logic [SW-1:0]   r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_shreg;
    logic [DBIT-1:0] r_data;
    logic            r_done;
    logic            r_ferr;
    logic            r_busy;
`ifdef UART_RX_PARITY_EN
    logic            r_perr;
    logic            r_par_mis;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= IDLE;
            r_s       <= '0;
            r_n       <= '0;
            r_shreg   <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr    <= 1'b0;
            r_par_mis <= 1'b0;
`endif
        end else begin
            r_rx_meta <= Rx;
            r_rx_s    <= r_rx_meta;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr    <= 1'b0;
`endif
            case (r_state)
                // Start detection runs every Clk so the edge is caught within one Clk of rx_s falling.
                IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= START;
                        r_s     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (Tick) begin
                        if (r_s == C_MID) begin
                            if (!r_rx_s) begin
                                r_state <= DATA;
                                r_s     <= '0;
                                r_n     <= '0;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (Tick) begin
                        if (r_s == C_BIT) begin
                            r_shreg <= {r_rx_s, r_shreg[DBIT-1:1]};
                            r_s     <= '0;
                            if (r_n == C_LAST) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= PARITY;
`else
                                r_state <= STOP;
`endif
                            end else begin
                                r_n <= r_n + NW'(1);
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (Tick) begin
                        if (r_s == C_BIT) begin
                            r_par_mis <= r_rx_s ^ (^r_shreg);
                            r_s       <= '0;
                            r_state   <= STOP;
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
`endif
                STOP: begin
                    if (Tick) begin
                        if (r_s == C_STOP) begin
                            r_data <= r_shreg;
                            r_s    <= '0;
`ifdef UART_RX_PARITY_EN
                            r_perr <= r_par_mis;
`endif
                            if (r_rx_s) begin
                                r_done  <= 1'b1;
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_ferr  <= 1'b1;
                                r_state <= BREAK;
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                // A held-low line must rise before another start bit can be recognised.
                BREAK: begin
                    if (r_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign RxData   = r_data;
    assign RxDone   = r_done;
    assign FrameErr = r_ferr;
    assign Busy     = r_busy;
`ifdef UART_RX_PARITY_EN
    assign ParityErr = r_perr;
`else
    assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: directed frames queue expectations, a monitor checks strobes.
// Tick period is shortened from the 9600-baud divider so the run stays short.
module tb_uart_rx_oversampled;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   tick_div = 4;
    int   tcnt     = 0;

    uart_rx_oversampled #(.DBIT(8), .SB_TICK(16)) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .Tick      (tick),
        .Rx        (rx),
        .RxData    (rx_data),
        .RxDone    (rx_done),
        .FrameErr  (frame_err),
        .ParityErr (parity_err),
        .Busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt++;
            if (tcnt >= tick_div) begin
                tcnt = 0;
                tick = 1'b1;
            end else begin
                tick = 1'b0;
            end
        end
    end

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (rx_done || frame_err || parity_err)) begin
            exp_t e;
            n_checks++;
            if (q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_strobe: done=%0b ferr=%0b perr=%0b data=%02h, required no strobe",
                         rx_done, frame_err, parity_err, rx_data);
            end else begin
                e = q.pop_front();
                if (rx_done !== ~e.ferr || frame_err !== e.ferr || parity_err !== e.perr || rx_data !== e.data) begin
                    n_fails++;
                    $display("FAIL frame_result: done=%0b ferr=%0b perr=%0b data=%02h, required done=%0b ferr=%0b perr=%0b data=%02h",
                             rx_done, frame_err, parity_err, rx_data, ~e.ferr, e.ferr, e.perr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(16 * tick_div);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        exp_t e;
        e.ferr = ~stop;
        e.perr = PAR_ON & (par != ^data);
        e.data = data;
        q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        if (PAR_ON) send_bit(par);
        send_bit(stop);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (q.size() != 0 && k < 4000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(name, q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;

        // Reset values
        wait_clks(5);
        check("reset_rxdata", rx_data, 8'h00);
        check("reset_rxdone", rx_done, 1'b0);
        check("reset_ferr", frame_err, 1'b0);
        check("reset_perr", parity_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        wait_clks(20);
        check("idle_busy", busy, 1'b0);

        // Single frame 0xA5
        send_frame(8'hA5, 1'b0, 1'b1);
        drain("a5_received");
        wait_clks(4);
        check("a5_busy_low", busy, 1'b0);

        // Glitch shorter than half a bit is rejected
        rx = 1'b0;
        wait_clks(4 * tick_div);
        rx = 1'b1;
        wait_clks(32 * tick_div);
        check("glitch_busy", busy, 1'b0);
        check("glitch_data_held", rx_data, 8'hA5);

        // Framing error then break held for three bit times
        send_frame(8'h3C, 1'b0, 1'b0);
        drain("3c_ferr");
        rx = 1'b0;
        wait_clks(32 * tick_div);
        check("break_busy", busy, 1'b1);
        rx = 1'b1;
        wait_clks(6);
        check("break_release", busy, 1'b0);
        wait_clks(16 * tick_div);

        // Back-to-back frames
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1);
        drain("b2b_three");

        // Reset during bit 4 of 0x81
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i == 0);
        rx = 1'b0;
        wait_clks(8 * tick_div);
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_clks(3);
        check("midreset_busy", busy, 1'b0);
        check("midreset_data", rx_data, 8'h00);
        rst_n = 1'b1;
        wait_clks(32 * tick_div);
        check("midreset_idle", busy, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b1);
        drain("7e_after_reset");

        // Tick held high continuously
        tick_div = 1;
        wait_clks(4);
        send_frame(8'hC3, 1'b0, 1'b1);
        drain("c3_tick_high");
        tick_div = 4;
        wait_clks(16);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h5A, 1'b1, 1'b1);
        drain("5a_bad_parity");
        send_frame(8'h5A, 1'b0, 1'b1);
        drain("5a_good_parity");
`endif

        wait_clks(64);
        check("final_queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
